// File: rtl/conv_window_loader_if.sv
// -----------------------------------------------------------------------------
// conv_window_loader_if
// Bundles the request, image-memory read port and window-output handshake of
// the convolution window loader.
//
// Signals:
//   start, origin_x, origin_y, matrix_size : window request (sampled in IDLE)
//   mem_rd, mem_addr                       : image-memory read strobe/address
//   mem_rdata                              : read data, one cycle after mem_rd
//   pixel_window, window_size              : packed 25-slot window + its size
//   window_valid, window_ready             : output handshake
//   busy                                   : loader not idle
//
// Modports:
//   slave  : the loader itself
//   master : the environment (requester, memory, consumer)
// -----------------------------------------------------------------------------
interface conv_window_loader_if #(
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 8
);
    logic                start;
    logic [COORD_W-1:0]  origin_x;
    logic [COORD_W-1:0]  origin_y;
    logic [1:0]          matrix_size;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_rdata;
    logic [199:0]        pixel_window;
    logic [1:0]          window_size;
    logic                window_valid;
    logic                window_ready;
    logic                busy;

    modport slave (
        input  start, origin_x, origin_y, matrix_size, mem_rdata, window_ready,
        output mem_rd, mem_addr, pixel_window, window_size, window_valid, busy
    );

    modport master (
        output start, origin_x, origin_y, matrix_size, mem_rdata, window_ready,
        input  mem_rd, mem_addr, pixel_window, window_size, window_valid, busy
    );
endinterface

// File: rtl/conv_window_loader.sv
// -----------------------------------------------------------------------------
// conv_window_loader
// Fetches an NxN (N = 2..5) pixel neighbourhood from image memory, one element
// per cycle in row-major order, and packs it into a 25-slot, 200-bit vector
// (slot = row*5 + col, slot k at bits [8k+7:8k]). Elements outside the image
// are not read and their slots stay zero. The finished window is presented
// with a valid/ready handshake together with the size code it was built for.
//
// Ports:
//   clk      : system clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : conv_window_loader_if.slave (request, memory port, output)
// -----------------------------------------------------------------------------
module conv_window_loader #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int COORD_W    = 8,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    conv_window_loader_if.slave   bus
);
    // Coordinates are extended by 3 bits so origin + offset (max 4) never wraps.
    localparam int XW = COORD_W + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_PRESENT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [COORD_W-1:0] r_ox;
    logic [COORD_W-1:0] r_oy;
    logic [1:0]         r_size;
    logic [2:0]         r_row;
    logic [2:0]         r_col;

    // One-deep tag for the read in flight: data returns on the next edge.
    logic               r_tag_valid;
    logic [4:0]         r_tag_slot;

    logic [2:0]         w_n;
    logic               w_last_col;
    logic               w_last_elem;
    logic [XW-1:0]      w_px;
    logic [XW-1:0]      w_py;
    logic               w_in_bounds;
    logic [4:0]         w_slot;
    logic               w_start_acc;
    logic               w_mem_rd;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic [199:0]       w_window;

    // ---------------------------------------------------------------- decode
    assign w_n         = {1'b0, r_size} + 3'd2;
    assign w_last_col  = (r_col == (w_n - 3'd1));
    assign w_last_elem = w_last_col && (r_row == (w_n - 3'd1));
    assign w_px        = XW'(r_ox) + XW'(r_col);
    assign w_py        = XW'(r_oy) + XW'(r_row);
    assign w_in_bounds = (w_px < XW'(IMG_WIDTH)) && (w_py < XW'(IMG_HEIGHT));
    assign w_slot      = ({2'b00, r_row} * 5'd5) + {2'b00, r_col};
    assign w_start_acc = (r_state == S_IDLE) && bus.start;

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_rd     = 1'b0;
        w_mem_addr   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_in_bounds) begin
                    w_mem_rd   = 1'b1;
                    // In-bounds addresses always fit ADDR_W, so truncation is safe.
                    w_mem_addr = ADDR_W'(w_py) * ADDR_W'(IMG_WIDTH) + ADDR_W'(w_px);
                end
                if (w_last_elem) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Lets the last read's data land before the window is shown.
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (bus.window_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------ request and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ox        <= '0;
            r_oy        <= '0;
            r_size      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_tag_valid <= 1'b0;
            r_tag_slot  <= '0;
        end else begin
            r_tag_valid <= w_mem_rd;
            r_tag_slot  <= w_slot;
            if (w_start_acc) begin
                r_ox   <= bus.origin_x;
                r_oy   <= bus.origin_y;
                r_size <= bus.matrix_size;
                r_row  <= '0;
                r_col  <= '0;
            end else if (r_state == S_FETCH) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 3'd1;
                end else begin
                    r_col <= r_col + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------- window slots
    // Each slot is its own byte register: cleared on an accepted start and
    // loaded when the tagged read for that slot returns.
    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_slot
            logic [7:0] r_pix;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pix <= '0;
                end else if (w_start_acc) begin
                    r_pix <= '0;
                end else if (r_tag_valid && (r_tag_slot == 5'(gi))) begin
                    r_pix <= bus.mem_rdata;
                end
            end

            assign w_window[8*gi +: 8] = r_pix;
        end
    endgenerate

    // --------------------------------------------------------------- outputs
    assign bus.mem_rd       = w_mem_rd;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.pixel_window = w_window;
    assign bus.window_size  = r_size;
    assign bus.window_valid = (r_state == S_PRESENT);
    assign bus.busy         = (r_state != S_IDLE);

endmodule
